// File: rtl/uart_hart_arbiter_pkg.sv
// Shared types and constants for the UART hart arbiter.
//   arb_state_e : arbiter FSM state (IDLE: no grant held, LOCKED: one owner).
//   NEWLINE     : byte that ends a line and releases the grant.
package uart_hart_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotated-priority picker.
//   req : request vector, one bit per requester
//   ptr : index with highest priority; the scan runs upward from here and wraps
//   gnt : one-hot of the first set request found (all-zero if none)
//   idx : index of that request (0 if none)
module uart_rr_pick
  import uart_hart_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_hart_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream between N_REQ harts.
// A grant is held until a newline is accepted, MAX_BURST bytes have been
// accepted, or the owner has been quiet for TIMEOUT cycles.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid_i  : per-requester byte valid
//   req_data_i   : per-requester byte, requester i at [8*i +: 8]
//   req_ready_o  : per-requester accept (only the owner's bit can be set)
//   tx_valid_o   : registered byte valid toward the UART FIFO
//   tx_data_o    : registered byte toward the UART FIFO
//   tx_ready_i   : UART FIFO can accept
//   grant_o      : one-hot current owner, zero when idle
//   owner_o      : index of the current (or last) owner
//   busy_o       : a grant is held or a byte is pending in the output register
module uart_hart_arbiter
  import uart_hart_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*8-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     busy_o
);

  localparam int unsigned IdxW       = $clog2(N_REQ);
  localparam logic [7:0]  BurstLimit = 8'(MAX_BURST);
  localparam logic [15:0] IdleLimit  = 16'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [15:0]     idle_cnt_q, idle_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]  pick_idx;
  logic             owner_valid;
  logic [7:0]       owner_data;
  logic             out_free;
  logic             accept;
  logic             release_now;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Select the current owner's request lines.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_valid = req_valid_i[i];
        owner_data  = req_data_i[i*8 +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          state_d     = LOCKED;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          idle_cnt_d  = '0;
          release_now = (owner_data == NEWLINE) || (burst_cnt_d == BurstLimit);
        end else if (!owner_valid) begin
          // A stalled-but-valid owner is not idle; only an absent byte counts.
          idle_cnt_d  = idle_cnt_q + 16'd1;
          release_now = (idle_cnt_d == IdleLimit);
        end
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The output register drains on its own, independent of grant release.
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = owner_data;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  // Outputs. req_ready_o depends only on registered state and tx_ready_i.
  always_comb begin
    out_free    = ~tx_valid_q | tx_ready_i;
    req_ready_o = '0;
    grant_o     = '0;
    if (state_q == LOCKED) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (owner_q == IdxW'(i)) begin
          grant_o[i]     = 1'b1;
          req_ready_o[i] = out_free;
        end
      end
    end
    accept = (state_q == LOCKED) & out_free & owner_valid;
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q == LOCKED) | tx_valid_q;

endmodule

// File: tb/tb_uart_hart_arbiter.sv
// Bench for uart_hart_arbiter (N_REQ=3, MAX_BURST=4, TIMEOUT=8).
// Stimulus loads per-requester byte sources and pushes the expected UART byte
// order into a queue; a monitor pops and compares each byte leaving the DUT.
module tb_uart_hart_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid_i;
  logic [23:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic [2:0]  grant_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] expq[$];
  logic [7:0] mem [3][64];
  int         wr  [3];
  int         rd  [3];
  logic [2:0] xfer;

  uart_hart_arbiter #(
    .N_REQ     (3),
    .MAX_BURST (4),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every byte the UART takes must be the next expected one.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid_o && tx_ready_i) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL tx_byte: got %02h, expected nothing", tx_data_o);
        end else begin
          e = expq.pop_front();
          if (tx_data_o !== e) begin
            bad++;
            $display("FAIL tx_byte: got %02h, expected %02h", tx_data_o, e);
          end
        end
      end
    end
  end

  task automatic drive();
    for (int r = 0; r < 3; r++) begin
      req_valid_i[r]        = (rd[r] < wr[r]);
      req_data_i[r*8 +: 8]  = (rd[r] < wr[r]) ? mem[r][rd[r]] : 8'h00;
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance sources after the edge.
  task automatic step();
    @(negedge clk);
    xfer = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) if (xfer[r]) rd[r]++;
    drive();
  endtask

  task automatic send(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      mem[r][wr[r]] = s[i];
      wr[r]++;
    end
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_o) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(expq.size() == 0 && !busy_o), 32'd1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data_o), 32'd0);
    check({name, "_ready"}, 32'(req_ready_o), 32'd0);
    check({name, "_grant"}, 32'(grant_o), 32'd0);
    check({name, "_owner"}, 32'(owner_o), 32'd0);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic clear_sources();
    expq.delete();
    for (int r = 0; r < 3; r++) begin
      wr[r] = 0;
      rd[r] = 0;
    end
    drive();
  endtask

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unstable;
    rst_n       = 1'b0;
    tx_ready_i  = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    xfer        = '0;
    for (int r = 0; r < 3; r++) begin
      wr[r] = 0;
      rd[r] = 0;
    end
    #1;
    check_zero_outputs("reset");
    step();
    step();
    rst_n = 1'b1;

    // Single requester: "ab\n" from req1.
    send(1, "ab\n");
    expect_str("ab\n");
    drive();
    check("t1_grant_t0", 32'(grant_o), 32'd0);
    step();
    check("t1_grant_t1", 32'(grant_o), 32'b010);
    check("t1_owner_t1", 32'(owner_o), 32'd1);
    check("t1_ready_t1", 32'(req_ready_o), 32'b010);
    step();
    check("t1_tx_valid_t2", 32'(tx_valid_o), 32'd1);
    check("t1_tx_data_t2", 32'(tx_data_o), 32'h61);
    step();
    check("t1_tx_data_t3", 32'(tx_data_o), 32'h62);
    step();
    check("t1_grant_t4", 32'(grant_o), 32'd0);
    check("t1_busy_t4", 32'(busy_o), 32'd1);
    check("t1_tx_data_t4", 32'(tx_data_o), 32'h0A);
    step();
    check("t1_busy_t5", 32'(busy_o), 32'd0);
    drain("t1_drain", 20);

    // Contention from reset: req0 then req2, one idle cycle between.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    send(0, "xy\n");
    send(2, "xy\n");
    expect_str("xy\nxy\n");
    drive();
    step();
    check("t2_grant_first", 32'(grant_o), 32'b001);
    step();
    step();
    step();
    check("t2_grant_gap", 32'(grant_o), 32'd0);
    step();
    check("t2_grant_second", 32'(grant_o), 32'b100);
    check("t2_tx_valid_gap", 32'(tx_valid_o), 32'd0);
    drain("t2_drain", 30);

    // Burst cap: req0 streams 10 bytes, req1 pending with "k\n".
    send(0, "0123456789");
    send(1, "k\n");
    expect_str("0123k\n456789");
    drive();
    step();
    check("t3_grant_req0", 32'(grant_o), 32'b001);
    repeat (4) step();
    check("t3_release_cap", 32'(grant_o), 32'd0);
    step();
    check("t3_grant_req1", 32'(grant_o), 32'b010);
    step();
    step();
    check("t3_release_nl", 32'(grant_o), 32'd0);
    step();
    check("t3_grant_req0_again", 32'(grant_o), 32'b001);
    drain("t3_drain", 60);

    // Timeout: req1 sends 2 bytes then goes quiet while req0 waits.
    send(1, "pq");
    send(0, "z\n");
    expect_str("pqz\n");
    drive();
    step();
    check("t4_grant_req1", 32'(grant_o), 32'b010);
    repeat (9) step();
    check("t4_held_8_idle", 32'(grant_o), 32'b010);
    step();
    check("t4_revoked", 32'(grant_o), 32'd0);
    step();
    check("t4_grant_req0", 32'(grant_o), 32'b001);
    drain("t4_drain", 30);

    // Backpressure: 20 stalled cycles mid-line, valid held high, no revoke.
    send(2, "mn\n");
    expect_str("mn\n");
    tx_ready_i = 1'b0;
    drive();
    step();
    check("t5_grant_req2", 32'(grant_o), 32'b100);
    check("t5_ready_first", 32'(req_ready_o), 32'b100);
    step();
    check("t5_tx_data", 32'(tx_data_o), 32'h6D);
    check("t5_ready_stalled", 32'(req_ready_o), 32'd0);
    unstable = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (tx_data_o !== 8'h6D || tx_valid_o !== 1'b1 || req_ready_o !== 3'b000 ||
          grant_o !== 3'b100)
        unstable++;
    end
    check("t5_stall_hold", 32'(unstable), 32'd0);
    tx_ready_i = 1'b1;
    drain("t5_drain", 30);

    // Move rr_ptr off zero so the post-reset priority check is meaningful.
    send(0, "w\n");
    expect_str("w\n");
    drive();
    drain("t6_pre_drain", 20);

    // Reset mid-operation, then req0 and req2 pending across reset.
    send(1, "rs\n");
    expect_str("rs\n");
    drive();
    step();
    check("t6_grant_req1", 32'(grant_o), 32'b010);
    step();
    check("t6_tx_valid_pre", 32'(tx_valid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    clear_sources();
    send(0, "u\n");
    send(2, "v\n");
    expect_str("u\nv\n");
    drive();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_grant_req0_after", 32'(grant_o), 32'b001);
    drain("t6_drain", 30);

    check("final_queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
